// File: rtl/mem_port_pkg.sv
// Shared types and encodings for the memory-port sequencer.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/enables shifted up by the lane offset, load data
// shifted down, truncated and sign/zero extended. Purely combinational.
module mem_lane_align
  import mem_port_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int BE_W  = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [1:0]       i_st_size,
  input  logic [OFF_W-1:0] i_st_off,
  input  logic [XLEN-1:0]  i_st_data,
  output logic [XLEN-1:0]  o_st_data,
  output logic [BE_W-1:0]  o_st_be,
  input  logic [1:0]       i_ld_size,
  input  logic [OFF_W-1:0] i_ld_off,
  input  logic             i_ld_unsigned,
  input  logic [XLEN-1:0]  i_ld_data,
  output logic [XLEN-1:0]  o_ld_data
);

  logic [BE_W-1:0] w_mask;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_keep;
  logic            w_sign;

  always_comb begin
    w_mask = '1;
    case (i_st_size)
      SZ_B:    w_mask = BE_W'(4'h1);
      SZ_H:    w_mask = BE_W'(4'h3);
      SZ_W:    w_mask = BE_W'(4'hF);
      default: w_mask = '1;
    endcase
    o_st_be   = w_mask << i_st_off;
    o_st_data = i_st_data << {i_st_off, 3'b000};
  end

  always_comb begin
    w_shift = i_ld_data >> {i_ld_off, 3'b000};
    w_keep  = '1;
    w_sign  = w_shift[XLEN-1];
    case (i_ld_size)
      SZ_B: begin w_keep = XLEN'(8'hFF);         w_sign = w_shift[7];  end
      SZ_H: begin w_keep = XLEN'(16'hFFFF);      w_sign = w_shift[15]; end
      SZ_W: begin w_keep = XLEN'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
      default: begin w_keep = '1;                w_sign = w_shift[XLEN-1]; end
    endcase
    o_ld_data = (w_shift & w_keep) | ({XLEN{w_sign & ~i_ld_unsigned}} & ~w_keep);
  end

endmodule

// File: rtl/mem_port_seq.sv
// Merges fetch and data requests onto one memory port; ack 2 cycles after sampling + mem wait cycles,
// faults ack after 1. Requests are held until ack. MEM_PORT_SEQ_TIMEOUT_EN adds a MAX_WAIT timeout.
module mem_port_seq
  import mem_port_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int ADDR_W   = 64,
  parameter int MAX_WAIT = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_ack,
  output logic [31:0]         fetch_instr,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [1:0]          data_size,
  input  logic                data_unsigned,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [XLEN-1:0]     data_wdata,
  output logic                data_ack,
  output logic [XLEN-1:0]     data_rdata,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rdy,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam bit HAS_D = (XLEN == 64);

  state_t r_state, w_next;

  logic              r_is_data, r_we, r_unsigned, r_fault;
  logic [1:0]        r_size, r_cause;
  logic [OFF_W-1:0]  r_offset;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [XLEN-1:0]   r_wdata, r_rdata;

  logic              w_req, w_we, w_unsigned, w_misalign, w_timeout;
  logic [1:0]        w_size;
  logic [2:0]        w_lsb_mask;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_st_be;
  logic [XLEN-1:0]   w_st_data, w_ld_data;

  // Data wins arbitration; a fetch is treated as an unsigned word load.
  always_comb begin
    w_req      = data_req | fetch_req;
    w_addr     = data_req ? data_addr : fetch_addr;
    w_size     = data_req ? data_size : SZ_W;
    w_unsigned = data_req ? data_unsigned : 1'b1;
    w_we       = data_req & data_we;
    w_lsb_mask = 3'b111;
    case (w_size)
      SZ_B:    w_lsb_mask = 3'b000;
      SZ_H:    w_lsb_mask = 3'b001;
      SZ_W:    w_lsb_mask = 3'b011;
      default: w_lsb_mask = 3'b111;
    endcase
    w_misalign = (|(w_addr[2:0] & w_lsb_mask)) | (data_req & (data_size == SZ_D) & ~HAS_D);
  end

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .i_st_size     (w_size),
    .i_st_off      (w_addr[OFF_W-1:0]),
    .i_st_data     (data_wdata),
    .o_st_data     (w_st_data),
    .o_st_be       (w_st_be),
    .i_ld_size     (r_size),
    .i_ld_off      (r_offset),
    .i_ld_unsigned (r_unsigned),
    .i_ld_data     (mem_rdata),
    .o_ld_data     (w_ld_data)
  );

`ifdef MEM_PORT_SEQ_TIMEOUT_EN
  logic [7:0] r_wait;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                            r_wait <= '0;
    else if (r_state == IDLE)            r_wait <= '0;
    else if (r_state == ACCESS && !mem_rdy) r_wait <= r_wait + 8'd1;
  end

  assign w_timeout = (r_state == ACCESS) && !mem_rdy && (r_wait == 8'(MAX_WAIT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_misalign ? RESP : ACCESS;
      ACCESS:  if (mem_rdy || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_is_data  <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_fault    <= 1'b0;
      r_size     <= '0;
      r_cause    <= FC_NONE;
      r_offset   <= '0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_is_data  <= data_req;
          r_we       <= w_we;
          r_size     <= w_size;
          r_unsigned <= w_unsigned;
          r_offset   <= w_addr[OFF_W-1:0];
          r_addr     <= {w_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_be       <= w_we ? w_st_be : '1;
          r_wdata    <= w_we ? w_st_data : '0;
          r_rdata    <= '0;
          r_fault    <= w_misalign;
          r_cause    <= w_misalign ? FC_MISALIGN : FC_NONE;
        end
        ACCESS: begin
          if (mem_rdy) begin
            r_rdata <= r_we ? '0 : w_ld_data;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_cause <= FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Everything is gated by state so reset clears the port asynchronously.
  assign mem_req     = (r_state == ACCESS);
  assign mem_we      = mem_req & r_we;
  assign mem_addr    = mem_req ? r_addr : '0;
  assign mem_be      = mem_req ? r_be : '0;
  assign mem_wdata   = mem_req ? r_wdata : '0;
  assign fetch_ack   = (r_state == RESP) & ~r_is_data;
  assign data_ack    = (r_state == RESP) & r_is_data;
  assign fetch_instr = fetch_ack ? r_rdata[31:0] : '0;
  assign data_rdata  = data_ack ? r_rdata : '0;
  assign fault       = (r_state == RESP) & r_fault;
  assign fault_cause = (r_state == RESP) ? r_cause : FC_NONE;

endmodule
